// File: rtl/conv_kxk_stream.sv
// Weight-stationary streaming convolution: TAPS serially loaded weights, one activation per
// accepted cycle, output = bias + dot(weights, last TAPS activations) with optional ReLU and saturation.
module conv_kxk_stream #(
  parameter int X_BW   = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 16,
  parameter int TAPS   = 9,
  parameter int ACC_BW = 21,
  parameter int O_BW   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_w_load,
  input  logic signed [W_BW-1:0]   i_w,
  output logic                     o_w_full,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [X_BW-1:0]   i_x,
  input  logic signed [B_BW-1:0]   i_bias,
  input  logic                     i_relu,
  output logic                     o_valid,
  output logic signed [O_BW-1:0]   o_y,
  output logic                     o_sat
);

  localparam int WC_BW = $clog2(TAPS + 1);
  localparam int HC_BW = $clog2(TAPS);
  localparam logic [WC_BW-1:0] W_FULL = WC_BW'(TAPS);
  localparam logic [HC_BW-1:0] H_FULL = HC_BW'(TAPS - 1);
  localparam logic signed [ACC_BW-1:0] Y_MAX = {{(ACC_BW - O_BW + 1){1'b0}}, {(O_BW - 1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] Y_MIN = {{(ACC_BW - O_BW + 1){1'b1}}, {(O_BW - 1){1'b0}}};

  logic signed [W_BW-1:0]   w_reg  [TAPS];
  logic signed [W_BW-1:0]   w_in   [TAPS];
  logic signed [X_BW-1:0]   x_reg  [TAPS];
  logic signed [X_BW-1:0]   x_next [TAPS];
  logic signed [ACC_BW-1:0] prod   [TAPS];
  logic [WC_BW-1:0]         w_cnt_reg;
  logic [HC_BW-1:0]         warm_cnt_reg;
  logic                     accept;
  logic                     warm_done;
  logic signed [ACC_BW-1:0] acc;
  logic signed [ACC_BW-1:0] res;
  logic signed [O_BW-1:0]   y_next;
  logic                     sat_next;

  assign o_w_full  = (w_cnt_reg == W_FULL);
  assign o_ready   = o_w_full & ~i_w_load & ~i_clear;
  assign accept    = i_valid & o_ready;
  assign warm_done = (warm_cnt_reg == H_FULL);

  // Products use the shifted-in history so the new sample contributes in its own accept cycle.
  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign w_in[gi]   = i_w;
        assign x_next[gi] = i_x;
      end else begin : g_body
        assign w_in[gi]   = w_reg[gi-1];
        assign x_next[gi] = x_reg[gi-1];
      end
      assign prod[gi] = ACC_BW'(w_reg[gi]) * ACC_BW'(x_next[gi]);
    end
  endgenerate

  always_comb begin
    acc = ACC_BW'(i_bias);
    for (int k = 0; k < TAPS; k++) begin
      acc = acc + prod[k];
    end
    res = acc;
    if (i_relu && acc[ACC_BW-1]) begin
      res = '0;
    end
    y_next   = res[O_BW-1:0];
    sat_next = 1'b0;
    if (res > Y_MAX) begin
      y_next   = Y_MAX[O_BW-1:0];
      sat_next = 1'b1;
    end else if (res < Y_MIN) begin
      y_next   = Y_MIN[O_BW-1:0];
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < TAPS; k++) begin
        w_reg[k] <= '0;
        x_reg[k] <= '0;
      end
      w_cnt_reg    <= '0;
      warm_cnt_reg <= '0;
      o_valid      <= 1'b0;
      o_y          <= '0;
      o_sat        <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_w_load) begin
        for (int k = 0; k < TAPS; k++) begin
          w_reg[k] <= w_in[k];
        end
        if (!o_w_full) begin
          w_cnt_reg <= w_cnt_reg + WC_BW'(1);
        end
      end
      // A new weight set or a flush discards history so outputs never mix contexts.
      if (i_w_load || i_clear) begin
        for (int k = 0; k < TAPS; k++) begin
          x_reg[k] <= '0;
        end
        warm_cnt_reg <= '0;
      end else if (accept) begin
        for (int k = 0; k < TAPS; k++) begin
          x_reg[k] <= x_next[k];
        end
        if (warm_done) begin
          o_valid <= 1'b1;
          o_y     <= y_next;
          o_sat   <= sat_next;
        end else begin
          warm_cnt_reg <= warm_cnt_reg + HC_BW'(1);
        end
      end
    end
  end

endmodule
